// File: rtl/mem_load_unit_pkg.sv
// rtl/mem_load_unit_pkg.sv - load opcodes, FSM states and the alignment legality rule.
// Honours LOAD_UNALIGNED_EN: when undefined, LWL/LWR are treated as illegal codes.
package mem_load_pkg;

  typedef enum logic [2:0] {
    LB   = 3'd0,
    LBU  = 3'd1,
    LH   = 3'd2,
    LHU  = 3'd3,
    LW   = 3'd4,
    LWL  = 3'd5,
    LWR  = 3'd6,
    LRSV = 3'd7
  } load_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DONE,
    ST_ERR
  } load_state_t;

  function automatic logic load_legal(load_type_t t, logic [1:0] off);
    logic ok;
    case (t)
      LB, LBU:  ok = 1'b1;
      LH, LHU:  ok = ~off[0];
      LW:       ok = (off == 2'b00);
`ifdef LOAD_UNALIGNED_EN
      LWL, LWR: ok = 1'b1;
`endif
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// rtl/mem_load_unit_if.sv - request/response and data-bus signals of the load unit.
interface mem_load_unit_if;
  import mem_load_pkg::*;

  logic        start;
  load_type_t  load_type;
  logic [31:0] addr;
  logic [31:0] rt_old;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        addr_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport slave (
    input  start, load_type, addr, rt_old, mem_readdata, mem_waitrequest,
    output busy, done, result, addr_err, mem_address, mem_read, mem_byteenable
  );

  modport master (
    output start, load_type, addr, rt_old, mem_readdata, mem_waitrequest,
    input  busy, done, result, addr_err, mem_address, mem_read, mem_byteenable
  );

endinterface

// File: rtl/eight_bit_extension.sv
// rtl/eight_bit_extension.sv - sign-extends a byte to 32 bits.
module eight_bit_extension (
  input  logic [7:0]  data_i,
  output logic [31:0] data_o
);
  assign data_o = {{24{data_i[7]}}, data_i};
endmodule

// File: rtl/mem_load_unit_extract.sv
// rtl/mem_load_unit_extract.sv - lane select, extension and LWL/LWR merge (combinational).
// The merge datapath exists only when LOAD_UNALIGNED_EN is defined.
module load_extract
  import mem_load_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  load_type_t  type_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] result_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] byte_sx;
  logic [31:0] half_sx;

  // Little-endian lanes: offset bit 1 picks the halfword, bit 0 the byte within it.
  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  assign byte_sel = offset_i[0] ? half_sel[15:8] : half_sel[7:0];

  eight_bit_extension u_sx8 (
    .data_i (byte_sel),
    .data_o (byte_sx)
  );

  sixteen_bit_extension u_sx16 (
    .data_i (half_sel),
    .data_o (half_sx)
  );

`ifdef LOAD_UNALIGNED_EN
  logic [4:0] lwl_sh;
  logic [4:0] lwr_sh;
  assign lwl_sh = {~offset_i, 3'b000};
  assign lwr_sh = {offset_i, 3'b000};
`else
  logic unused_rt;
  assign unused_rt = ^rt_old_i;
`endif

  always_comb begin
    result_o = '0;
    case (type_i)
      LB:  result_o = byte_sx;
      LBU: result_o = {24'b0, byte_sel};
      LH:  result_o = half_sx;
      LHU: result_o = {16'b0, half_sel};
      LW:  result_o = word_i;
`ifdef LOAD_UNALIGNED_EN
      LWL: result_o = (word_i << lwl_sh) | (rt_old_i & ((32'h1 << lwl_sh) - 32'h1));
      LWR: result_o = (word_i >> lwr_sh) | (rt_old_i & ~(32'hFFFF_FFFF >> lwr_sh));
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/sixteen_bit_extension.sv
// rtl/sixteen_bit_extension.sv - sign-extends a halfword to 32 bits.
module sixteen_bit_extension (
  input  logic [15:0] data_i,
  output logic [31:0] data_o
);
  assign data_o = {{16{data_i[15]}}, data_i};
endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - load FSM: one word read on the data bus, then extract/extend.
// LWL/LWR support is selected by LOAD_UNALIGNED_EN.
module mem_load_unit
  import mem_load_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mem_load_unit_if.slave  bus
);

  load_state_t state_q;
  load_type_t  type_q;
  logic [31:0] addr_q;
  logic [31:0] rt_old_q;
  logic [31:0] result_q;
  logic [31:0] result_d;

  load_extract u_extract (
    .word_i   (bus.mem_readdata),
    .offset_i (addr_q[1:0]),
    .type_i   (type_q),
    .rt_old_i (rt_old_q),
    .result_o (result_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      type_q   <= LB;
      addr_q   <= '0;
      rt_old_q <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            type_q   <= bus.load_type;
            addr_q   <= bus.addr;
            rt_old_q <= bus.rt_old;
            if (load_legal(bus.load_type, bus.addr[1:0])) begin
              state_q <= ST_READ;
            end else begin
              result_q <= '0;
              state_q  <= ST_ERR;
            end
          end
        end
        ST_READ: begin
          if (!bus.mem_waitrequest) begin
            result_q <= result_d;
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Everything below depends only on registered state, never on the bus inputs.
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign bus.addr_err       = (state_q == ST_ERR);
  assign bus.result         = result_q;
  assign bus.mem_read       = (state_q == ST_READ);
  assign bus.mem_address    = {addr_q[31:2], 2'b00};
  assign bus.mem_byteenable = (state_q == ST_READ) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - scoreboard bench for mem_load_unit with a byte-level reference model.
module tb_mem_load_unit;
  import mem_load_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_load_unit_if bus ();

  mem_load_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   done_seen  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: works on an array of bytes and plain integer arithmetic.
  function automatic void model(input load_type_t lt, input logic [31:0] a, input logic [31:0] rt,
                                input logic [31:0] w, output logic [31:0] res, output logic err);
    logic [7:0] b[4];
    logic [7:0] r[4];
    int k;
    int h;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      b[i] = w[8*i +: 8];
      r[i] = rt[8*i +: 8];
    end
    err = 1'b0;
    res = 32'h0;
    case (lt)
      LB:  res = (b[k] >= 8'd128) ? 32'(int'(b[k]) - 256) : 32'(b[k]);
      LBU: res = 32'(b[k]);
      LH, LHU: begin
        if (k % 2 != 0) err = 1'b1;
        else begin
          h = int'(b[(k+1)%4]) * 256 + int'(b[k]);
          res = (lt == LH && h >= 32768) ? 32'(h - 65536) : 32'(h);
        end
      end
      LW: begin
        if (k != 0) err = 1'b1;
        else res = w;
      end
`ifdef LOAD_UNALIGNED_EN
      LWL: begin
        for (int j = 0; j <= k; j++) r[3-j] = b[k-j];
        res = {r[3], r[2], r[1], r[0]};
      end
      LWR: begin
        for (int j = 0; j <= 3 - k; j++) r[j] = b[k+j];
        res = {r[3], r[2], r[1], r[0]};
      end
`endif
      default: err = 1'b1;
    endcase
  endfunction

  task automatic do_load(input load_type_t lt, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] w, input int waits, input bit spam,
                         input bit use_exp, input logic [31:0] eres, input logic eerr);
    exp_t e;
    logic [31:0] mres;
    logic merr;
    int t;
    model(lt, a, rt, w, mres, merr);
    if (use_exp) begin
      mres = eres;
      merr = eerr;
    end
    @(negedge clk);
    bus.start           = 1'b1;
    bus.load_type       = lt;
    bus.addr            = a;
    bus.rt_old          = rt;
    bus.mem_readdata    = w;
    bus.mem_waitrequest = (waits != 0);
    e.res = mres;
    e.err = merr;
    e.cyc = cyc + (merr ? 1 : 2 + waits);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (spam) begin
      bus.load_type = load_type_t'($urandom_range(0, 7));
      bus.addr      = $urandom;
      bus.rt_old    = $urandom;
    end else begin
      bus.start = 1'b0;
    end
    if (!merr) begin
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        check("mem_read", {31'b0, bus.mem_read}, 32'd1);
        check("mem_address", bus.mem_address, {a[31:2], 2'b00});
        check("mem_byteenable", {28'b0, bus.mem_byteenable}, 32'hF);
        bus.mem_waitrequest = (i < waits);
      end
    end else begin
      @(negedge clk);
      check("err_no_read", {31'b0, bus.mem_read}, 32'd0);
    end
    t = 0;
    while (!bus.done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", {31'b0, bus.done}, 32'd1);
    if (!bus.done) sb.delete();
    @(posedge clk);
    #1;
    bus.start           = 1'b0;
    bus.mem_waitrequest = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      done_seen++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending load (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", bus.result, mon_e.res);
        check("addr_err", {31'b0, bus.addr_err}, {31'b0, mon_e.err});
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int d0;
    reset               = 1'b1;
    bus.start           = 1'b0;
    bus.load_type       = LB;
    bus.addr            = '0;
    bus.rt_old          = '0;
    bus.mem_readdata    = '0;
    bus.mem_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_addr_err", {31'b0, bus.addr_err}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
    check("rst_mem_address", bus.mem_address, 32'd0);
    check("rst_mem_byteenable", {28'b0, bus.mem_byteenable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_load(LB, 32'h0, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'h00000001, 1'b0);
    do_load(LB, 32'h1, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'h0000007F, 1'b0);
    do_load(LB, 32'h2, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'hFFFFFFFF, 1'b0);
    do_load(LB, 32'h3, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'hFFFFFF80, 1'b0);
    do_load(LBU, 32'h3, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'h00000080, 1'b0);
    do_load(LHU, 32'h2, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'h000080FF, 1'b0);
    do_load(LH, 32'h2, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'hFFFF80FF, 1'b0);
    do_load(LH, 32'h0, 32'h0, 32'h80FF7F01, 0, 0, 1, 32'h00007F01, 1'b0);
    do_load(LW, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 1, 32'hDEADBEEF, 1'b0);
    do_load(LW, 32'h102, 32'h0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 1'b1);
    do_load(LH, 32'h101, 32'h0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 1'b1);
    do_load(LRSV, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 1'b1);
`ifdef LOAD_UNALIGNED_EN
    do_load(LWL, 32'h1, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'hCCDD3344, 1'b0);
    do_load(LWR, 32'h1, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'h11AABBCC, 1'b0);
`else
    do_load(LWL, 32'h1, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'h0, 1'b1);
    do_load(LWR, 32'h1, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'h0, 1'b1);
`endif
    do_load(LB, 32'h2, 32'h0, 32'h80FF7F01, 2, 1, 1, 32'hFFFFFFFF, 1'b0);

    // Abort a stalled read with reset; no done may follow.
    d0 = done_seen;
    @(negedge clk);
    bus.start           = 1'b1;
    bus.load_type       = LW;
    bus.addr            = 32'h200;
    bus.mem_waitrequest = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_pre_read", {31'b0, bus.mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_mem_read", {31'b0, bus.mem_read}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    reset               = 1'b0;
    bus.mem_waitrequest = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_seen, d0);

    repeat (150) begin
      do_load(load_type_t'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0, 32'h0, 1'b0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
